// File: rtl/vx_om_mem_responder.sv
// Word-addressed 32-bit memory with byte-enabled writes and fixed-latency,
// in-order, credit-limited tagged read responses.
module vx_om_mem_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int TAG_WIDTH  = 4,
  parameter int LATENCY    = 2,
  parameter int QUEUE_SIZE = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_rw,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [3:0]            req_byteen,
  input  logic [31:0]           req_data,
  input  logic [TAG_WIDTH-1:0]  req_tag,
  output logic                  req_ready,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_data,
  output logic [TAG_WIDTH-1:0]  rsp_tag,
  input  logic                  rsp_ready,
  output logic                  busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int QAW   = $clog2(QUEUE_SIZE);
  localparam int CW    = QAW + 1;

  logic [31:0]          r_mem [DEPTH];
  logic [LATENCY-1:0]   r_pipe_vld;
  logic [31:0]          r_pipe_data [LATENCY];
  logic [TAG_WIDTH-1:0] r_pipe_tag [LATENCY];
  logic [31:0]          r_q_data [QUEUE_SIZE];
  logic [TAG_WIDTH-1:0] r_q_tag [QUEUE_SIZE];
  logic [QAW-1:0]       r_q_wr_ptr;
  logic [QAW-1:0]       r_q_rd_ptr;
  logic [CW-1:0]        r_q_count;
  logic [CW-1:0]        r_pending;

  logic w_req_fire;
  logic w_rd_fire;
  logic w_wr_fire;
  logic w_rsp_fire;
  logic w_q_push;

  assign w_req_fire = req_valid && req_ready;
  assign w_rd_fire  = w_req_fire && !req_rw;
  assign w_wr_fire  = w_req_fire && req_rw;
  assign w_rsp_fire = rsp_valid && rsp_ready;
  assign w_q_push   = r_pipe_vld[LATENCY-1];

  // Credit check uses only registered state, so no input reaches req_ready.
  assign req_ready = (r_pending < CW'(QUEUE_SIZE));
  assign busy      = (r_pending != '0);
  assign rsp_valid = (r_q_count != '0);
  assign rsp_data  = r_q_data[r_q_rd_ptr];
  assign rsp_tag   = r_q_tag[r_q_rd_ptr];

  // Memory is intentionally never reset.
  always_ff @(posedge clk) begin
    if (w_wr_fire) begin
      for (int i = 0; i < 4; i++) begin
        if (req_byteen[i]) r_mem[req_addr][8*i +: 8] <= req_data[8*i +: 8];
      end
    end
  end

  // Stage 0 samples the word at accept time, so a preceding write is visible.
  always_ff @(posedge clk) begin
    r_pipe_data[0] <= r_mem[req_addr];
    r_pipe_tag[0]  <= req_tag;
    for (int i = 1; i < LATENCY; i++) begin
      r_pipe_data[i] <= r_pipe_data[i-1];
      r_pipe_tag[i]  <= r_pipe_tag[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pipe_vld <= '0;
    end else begin
      r_pipe_vld[0] <= w_rd_fire;
      for (int i = 1; i < LATENCY; i++) r_pipe_vld[i] <= r_pipe_vld[i-1];
    end
  end

  // Response queue storage; the credit limit guarantees a free slot on push.
  always_ff @(posedge clk) begin
    if (w_q_push) begin
      r_q_data[r_q_wr_ptr] <= r_pipe_data[LATENCY-1];
      r_q_tag[r_q_wr_ptr]  <= r_pipe_tag[LATENCY-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q_wr_ptr <= '0;
      r_q_rd_ptr <= '0;
      r_q_count  <= '0;
      r_pending  <= '0;
    end else begin
      if (w_q_push)   r_q_wr_ptr <= r_q_wr_ptr + QAW'(1);
      if (w_rsp_fire) r_q_rd_ptr <= r_q_rd_ptr + QAW'(1);
      case ({w_q_push, w_rsp_fire})
        2'b10:   r_q_count <= r_q_count + CW'(1);
        2'b01:   r_q_count <= r_q_count - CW'(1);
        default: r_q_count <= r_q_count;
      endcase
      case ({w_rd_fire, w_rsp_fire})
        2'b10:   r_pending <= r_pending + CW'(1);
        2'b01:   r_pending <= r_pending - CW'(1);
        default: r_pending <= r_pending;
      endcase
    end
  end

endmodule
